// File: rtl/line_buf_reader.sv
// line_buf_reader: streams len words from a registered-read RAM to a valid/ready pixel port through a 2-entry skid FIFO
module line_buf_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] px_data,
  output logic                  px_valid,
  input  logic                  px_ready,
  output logic                  px_last,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam logic [ADDR_WIDTH-1:0] a_one = 1;
  localparam logic [ADDR_WIDTH:0]   r_one = 1;
  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   rem;
  logic                  inflight, inflight_last;
  logic [DATA_WIDTH-1:0] fifo_d [2];
  logic                  fifo_l [2];
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            occ;
  logic                  pop, rd_en;
  assign pop       = px_valid & px_ready;
  // words already stored plus the one still coming out of the RAM must fit in 2 slots
  assign rd_en     = (state == READ) && (rem != '0) &&
                     (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  assign ram_raddr = addr;
  assign px_valid  = occ != 2'd0;
  assign px_data   = fifo_d[rd_ptr];
  assign px_last   = px_valid & fifo_l[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      rem           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_d[0]     <= '0;
      fifo_d[1]     <= '0;
      fifo_l[0]     <= 1'b0;
      fifo_l[1]     <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      occ           <= 2'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      occ      <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= rd_en;
      inflight_last <= rem == r_one;
      if (inflight) begin
        fifo_d[wr_ptr] <= ram_rdata;
        fifo_l[wr_ptr] <= inflight_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
      if (rd_en) begin
        addr <= addr + a_one;
        rem  <= rem - r_one;
      end
      case (state)
        IDLE: if (start && len != '0) begin
          addr  <= base_addr;
          rem   <= len;
          state <= READ;
          busy  <= 1'b1;
        end
        READ: if (rd_en && rem == r_one) state <= DRAIN;
        DRAIN: if (pop && px_last) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
